// File: rtl/password_enroll.sv
// rtl/password_enroll.sv - keypad password enrollment with confirmation and status digit
//
// Records a CODE_LEN-symbol button sequence, requires it to be re-entered,
// then publishes it on code_out for the sequence checker.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   prog_req   in   one-cycle pulse, starts enrollment (honoured only in IDLE)
//   btn_pulse  in   one-cycle press pulses {U,D,L,R} = bits [3:0]
//   code_out   out  stored code, symbol k in bits [2k+1:2k]
//   busy       out  high while not IDLE
//   done       out  one-cycle pulse, new code committed
//   err        out  one-cycle pulse, enrollment aborted
//   SSG_D      out  seven-segment status digit gfedcba, active-low
module password_enroll #(
   parameter int                      CODE_LEN     = 4,
   parameter logic [2*CODE_LEN-1:0]   DEFAULT_CODE = 8'hE8,
   parameter int                      TIMEOUT_CYC  = 500000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    prog_req,
   input  logic [3:0]              btn_pulse,
   output logic [2*CODE_LEN-1:0]   code_out,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [6:0]              SSG_D
);

   localparam int CW = 2 * CODE_LEN;
   localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [IW-1:0] IDX_LAST = IW'(CODE_LEN - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TMR_MAX  = '1;

   localparam logic [6:0] SEG_E    = 7'b0000110;
   localparam logic [6:0] SEG_C    = 7'b1000110;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OK   = 7'b0010000;
   localparam logic [6:0] SEG_BAD  = 7'b0001110;

   typedef enum logic [2:0] {S_IDLE, S_ENTER, S_CONFIRM, S_COMMIT, S_FAIL} state_t;
   typedef enum logic [1:0] {R_NONE, R_OK, R_BAD} result_t;

   state_t          state_q, state_d;
   result_t         last_q, last_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [CW-1:0]   shadow_q, shadow_d;
   logic            mismatch_q, mismatch_d;
   logic [CW-1:0]   code_q, code_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [6:0]      ssg_q, ssg_d;

   logic            press_valid;
   logic            press_multi;
   logic [1:0]      sym;
   logic            mm;

   // One-hot press to symbol: bit3=U(00), bit2=D(01), bit1=L(10), bit0=R(11).
   assign press_valid = $onehot(btn_pulse);
   assign press_multi = (|btn_pulse) && !press_valid;
   assign sym         = {btn_pulse[1] | btn_pulse[0], btn_pulse[2] | btn_pulse[0]};

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      shadow_d   = shadow_q;
      mismatch_d = mismatch_q;
      code_d     = code_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      mm         = mismatch_q | (sym != shadow_q[{idx_q, 1'b0} +: 2]);

      case (state_q)
         S_IDLE: begin
            if (prog_req) begin
               state_d  = S_ENTER;
               idx_d    = '0;
               timer_d  = '0;
               shadow_d = '0;
            end
         end
         S_ENTER, S_CONFIRM: begin
            if (press_multi) begin
               state_d = S_FAIL;
            end else if (press_valid) begin
               timer_d = '0;
               if (state_q == S_ENTER) begin
                  shadow_d[{idx_q, 1'b0} +: 2] = sym;
                  if (idx_q == IDX_LAST) begin
                     state_d    = S_CONFIRM;
                     idx_d      = '0;
                     mismatch_d = 1'b0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  // Mismatch is accumulated silently; verdict only after the last symbol.
                  mismatch_d = mm;
                  if (idx_q == IDX_LAST) begin
                     state_d = mm ? S_FAIL : S_COMMIT;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end else if (timer_q == TMR_LAST) begin
               state_d = S_FAIL;
            end else if (timer_q != TMR_MAX) begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_COMMIT: begin
            code_d  = shadow_q;
            done_d  = 1'b1;
            last_d  = R_OK;
            state_d = S_IDLE;
         end
         S_FAIL: begin
            err_d   = 1'b1;
            last_d  = R_BAD;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);

      case (state_d)
         S_ENTER:   ssg_d = SEG_E;
         S_CONFIRM: ssg_d = SEG_C;
         default: begin
            case (last_d)
               R_OK:    ssg_d = SEG_OK;
               R_BAD:   ssg_d = SEG_BAD;
               default: ssg_d = SEG_DASH;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         last_q     <= R_NONE;
         idx_q      <= '0;
         timer_q    <= '0;
         shadow_q   <= '0;
         mismatch_q <= 1'b0;
         code_q     <= DEFAULT_CODE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ssg_q      <= SEG_DASH;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         shadow_q   <= shadow_d;
         mismatch_q <= mismatch_d;
         code_q     <= code_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ssg_q      <= ssg_d;
      end
   end

   assign code_out = code_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign SSG_D    = ssg_q;

endmodule

// File: tb/tb_password_enroll.sv
// tb/tb_password_enroll.sv - self-checking bench for password_enroll
module tb_password_enroll;

   localparam logic [3:0] BU = 4'b1000;
   localparam logic [3:0] BD = 4'b0100;
   localparam logic [3:0] BL = 4'b0010;
   localparam logic [3:0] BR = 4'b0001;

   localparam logic [6:0] SEG_E    = 7'b0000110;
   localparam logic [6:0] SEG_C    = 7'b1000110;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OK   = 7'b0010000;
   localparam logic [6:0] SEG_BAD  = 7'b0001110;

   logic       clk = 1'b0;
   logic       reset;
   logic       prog_req;
   logic [3:0] btn_pulse;
   logic [7:0] code_out;
   logic       busy, done, err;
   logic [6:0] SSG_D;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       is_done;
      logic [7:0] code;
      logic [6:0] ssg;
   } exp_t;

   exp_t sb_q[$];
   exp_t sb_e;

   password_enroll #(.CODE_LEN(4), .DEFAULT_CODE(8'hE8), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset), .prog_req(prog_req), .btn_pulse(btn_pulse),
      .code_out(code_out), .busy(busy), .done(done), .err(err), .SSG_D(SSG_D)
   );

   always #5 clk = ~clk;

   // Scoreboard: every done/err pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset && (done || err)) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected done=%0b err=%0b code=%h", done, err, code_out);
         end else begin
            sb_e = sb_q.pop_front();
            if ({done, err, code_out, SSG_D} !== {sb_e.is_done, !sb_e.is_done, sb_e.code, sb_e.ssg}) begin
               errors++;
               $display("FAIL sb_result got done=%0b err=%0b code=%h ssg=%b exp done=%0b code=%h ssg=%b",
                        done, err, code_out, SSG_D, sb_e.is_done, sb_e.code, sb_e.ssg);
            end
         end
      end
   end

   task automatic cyc(input logic p, input logic [3:0] b);
      prog_req  = p;
      btn_pulse = b;
      @(negedge clk);
      prog_req  = 1'b0;
      btn_pulse = 4'b0;
   endtask

   task automatic do_reset();
      prog_req  = 1'b0;
      btn_pulse = 4'b0;
      reset     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (code_out !== 8'hE8) begin errors++; $display("FAIL rst_code got %h exp e8", code_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b exp 00", {done, err}); end
      checks++; if (SSG_D !== SEG_DASH) begin errors++; $display("FAIL rst_ssg got %b exp %b", SSG_D, SEG_DASH); end
   endtask

   task automatic test_commit();
      logic [3:0] seq[4];
      seq = '{BD, BD, BU, BR};
      sb_q.push_back('{1'b1, 8'hC5, SEG_OK});
      cyc(1'b1, 4'b0);
      checks++; if ({busy, SSG_D} !== {1'b1, SEG_E}) begin errors++; $display("FAIL commit_enter got busy=%b ssg=%b", busy, SSG_D); end
      for (int i = 0; i < 4; i++) cyc(1'b0, seq[i]);
      checks++; if (SSG_D !== SEG_C) begin errors++; $display("FAIL commit_confirm_ssg got %b exp %b", SSG_D, SEG_C); end
      for (int i = 0; i < 4; i++) cyc(1'b0, seq[i]);
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL commit_state got busy=%b done=%b exp 1 0", busy, done); end
      cyc(1'b0, 4'b0);
      checks++; if ({done, code_out, busy, SSG_D} !== {1'b1, 8'hC5, 1'b0, SEG_OK}) begin
         errors++; $display("FAIL commit_done got done=%b code=%h busy=%b ssg=%b exp 1 c5 0 %b", done, code_out, busy, SSG_D, SEG_OK);
      end
      cyc(1'b0, 4'b0);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL commit_pulse_width got %b exp 0", done); end
   endtask

   task automatic test_mismatch();
      logic [3:0] ent[4];
      logic [3:0] con[4];
      ent = '{BD, BD, BU, BR};
      con = '{BD, BL, BU, BR};
      do_reset();
      sb_q.push_back('{1'b0, 8'hE8, SEG_BAD});
      cyc(1'b1, 4'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, ent[i]);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, con[i]);
         checks++; if ({err, busy} !== 2'b01) begin errors++; $display("FAIL mism_early press=%0d got err=%b busy=%b", i, err, busy); end
      end
      cyc(1'b0, 4'b0);
      checks++; if ({err, code_out, busy, SSG_D} !== {1'b1, 8'hE8, 1'b0, SEG_BAD}) begin
         errors++; $display("FAIL mism_err got err=%b code=%h busy=%b ssg=%b", err, code_out, busy, SSG_D);
      end
      cyc(1'b0, 4'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mism_pulse_width got %b exp 0", err); end
   endtask

   task automatic test_multi_press();
      sb_q.push_back('{1'b0, 8'hE8, SEG_BAD});
      cyc(1'b1, 4'b0);
      cyc(1'b0, BU);
      cyc(1'b0, 4'b1010);
      checks++; if ({err, busy} !== 2'b01) begin errors++; $display("FAIL multi_fail_state got err=%b busy=%b exp 0 1", err, busy); end
      cyc(1'b0, 4'b0);
      checks++; if ({err, busy, code_out} !== {1'b1, 1'b0, 8'hE8}) begin
         errors++; $display("FAIL multi_err got err=%b busy=%b code=%h", err, busy, code_out);
      end
   endtask

   task automatic test_timeout();
      sb_q.push_back('{1'b0, 8'hE8, SEG_BAD});
      cyc(1'b1, 4'b0);
      cyc(1'b0, BU);
      for (int q = 1; q <= 16; q++) begin
         cyc(1'b0, 4'b0);
         checks++; if ({err, busy} !== 2'b01) begin errors++; $display("FAIL tmo_early quiet=%0d got err=%b busy=%b", q, err, busy); end
      end
      cyc(1'b0, 4'b0);
      checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL tmo_err got err=%b busy=%b exp 1 0", err, busy); end
      // Asynchronous reset in the middle of CONFIRM.
      cyc(1'b1, 4'b0);
      cyc(1'b0, BD); cyc(1'b0, BD); cyc(1'b0, BU); cyc(1'b0, BR);
      cyc(1'b0, BD);
      checks++; if ({busy, SSG_D} !== {1'b1, SEG_C}) begin errors++; $display("FAIL arst_pre got busy=%b ssg=%b", busy, SSG_D); end
      #2 reset = 1'b0;
      #1;
      checks++; if ({code_out, busy, done, err, SSG_D} !== {8'hE8, 3'b000, SEG_DASH}) begin
         errors++; $display("FAIL arst_async got code=%h busy=%b done=%b err=%b ssg=%b", code_out, busy, done, err, SSG_D);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ignore_and_back_to_back();
      logic [3:0] seq[4];
      seq = '{BD, BD, BU, BR};
      cyc(1'b0, BL);
      checks++; if ({busy, done, err, SSG_D} !== {3'b000, SEG_DASH}) begin
         errors++; $display("FAIL idle_btn got busy=%b done=%b err=%b ssg=%b", busy, done, err, SSG_D);
      end
      cyc(1'b1, BD);
      cyc(1'b1, 4'b0);
      checks++; if ({busy, SSG_D} !== {1'b1, SEG_E}) begin errors++; $display("FAIL prog_in_enter got busy=%b ssg=%b", busy, SSG_D); end
      for (int i = 0; i < 3; i++) cyc(1'b0, seq[i]);
      checks++; if (SSG_D !== SEG_E) begin errors++; $display("FAIL idx_no_advance got ssg=%b exp %b", SSG_D, SEG_E); end
      cyc(1'b0, seq[3]);
      checks++; if (SSG_D !== SEG_C) begin errors++; $display("FAIL idx_to_confirm got ssg=%b exp %b", SSG_D, SEG_C); end
      sb_q.push_back('{1'b1, 8'hC5, SEG_OK});
      for (int i = 0; i < 4; i++) cyc(1'b0, seq[i]);
      cyc(1'b0, 4'b0);
      checks++; if ({done, code_out} !== {1'b1, 8'hC5}) begin errors++; $display("FAIL b2b_done got done=%b code=%h", done, code_out); end
      cyc(1'b1, 4'b0);
      checks++; if ({busy, SSG_D, code_out} !== {1'b1, SEG_E, 8'hC5}) begin
         errors++; $display("FAIL b2b_restart got busy=%b ssg=%b code=%h", busy, SSG_D, code_out);
      end
      do_reset();
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb_q.size()); end
   endtask

   initial begin
      reset     = 1'b0;
      prog_req  = 1'b0;
      btn_pulse = 4'b0;
      test_reset();
      test_commit();
      test_mismatch();
      test_multi_press();
      test_timeout();
      test_ignore_and_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
